// File: rtl/cache_traffic_gen_if.sv
// CPU-side port of the cache: request/address/data out of the generator,
// hit/miss/done back from the cache.
interface cache_traffic_gen_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
);
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_write_data;
  logic              cache_hit;
  logic              cache_miss;
  logic              done_signal;

  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_write_data,
    input  cache_hit, cache_miss, done_signal
  );

  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_write_data,
    output cache_hit, cache_miss, done_signal
  );
endinterface

// File: rtl/cache_traffic_gen.sv
// Pseudo-random cache request generator with hit/miss statistics, one access at a time.
// Optional watchdog on stuck accesses: define TRAFFIC_TIMEOUT_EN (adds timeout_count port).
module cache_traffic_gen #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 512,
  parameter int                CNT_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [31:0]       SEED_A      = 32'hACE1_2468,
  parameter logic [15:0]       SEED_W      = 16'hBEEF,
  parameter int                TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_accesses,
  input  logic [4:0]       region_log2,
  input  logic [8:0]       write_frac,
  output logic             busy,
  output logic             finished,
  output logic             err,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
`ifdef TRAFFIC_TIMEOUT_EN
  output logic [CNT_W-1:0] timeout_count,
`endif
  cache_traffic_gen_if.master bus
);
  localparam int          WORDS  = DATA_W / 32;
  localparam logic [31:0] TAPS_A = 32'h8020_0003;
  localparam logic [15:0] TAPS_W = 16'hB400;

  typedef enum logic [2:0] {IDLE, SETUP, REQ, WAIT_DONE, RELEASE, FINISH} state_t;

  state_t              state;
  logic [31:0]         lfsr_a;
  logic [15:0]         lfsr_w;
  logic [CNT_W-1:0]    num_q, issued_q, hit_q, miss_q;
  logic                busy_q, fin_q, err_q, rd_q, wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [WORDS-1:0][31:0] wpat;
  logic [31:0]         mask_a;
  logic                is_wr, resp, tmo_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Write data is a fixed golden-ratio pattern over the current address seed
  for (genvar i = 0; i < WORDS; i++) begin : g_word
    assign wpat[i] = lfsr_a ^ (32'(i) * 32'h9E37_79B9);
  end

  assign mask_a = (32'd1 << region_log2) - 32'd1;
  assign is_wr  = {1'b0, lfsr_w[7:0]} < write_frac;
  assign resp   = (state == REQ) ? (bus.cache_hit | bus.cache_miss | bus.done_signal)
                                 : bus.done_signal;

`ifdef TRAFFIC_TIMEOUT_EN
  logic [31:0]      wdog_q;
  logic [CNT_W-1:0] tmo_q;

  // Fires only when the access would otherwise keep waiting this cycle
  assign tmo_fire      = (state == REQ || state == WAIT_DONE) && !resp &&
                         (wdog_q == 32'(TIMEOUT_CYC - 1));
  assign timeout_count = tmo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
      tmo_q  <= '0;
    end else begin
      if (state == IDLE && start) tmo_q <= '0;
      else if (tmo_fire)          tmo_q <= sat_inc(tmo_q);
      if (state == REQ || state == WAIT_DONE) wdog_q <= wdog_q + 32'd1;
      else                                    wdog_q <= '0;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lfsr_a   <= SEED_A;
      lfsr_w   <= SEED_W;
      num_q    <= '0;
      issued_q <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          fin_q <= 1'b0;
          if (start) begin
            num_q    <= num_accesses;
            issued_q <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
            err_q    <= 1'b0;
            lfsr_a   <= SEED_A;
            lfsr_w   <= SEED_W;
            busy_q   <= 1'b1;
            state    <= (num_accesses == '0) ? FINISH : SETUP;
          end
        end
        SETUP: begin
          addr_q <= BASE_ADDR + ADDR_W'(lfsr_a & mask_a);
          data_q <= wpat;
          wr_q   <= is_wr;
          rd_q   <= !is_wr;
          lfsr_a <= {1'b0, lfsr_a[31:1]} ^ (lfsr_a[0] ? TAPS_A : 32'd0);
          lfsr_w <= {1'b0, lfsr_w[15:1]} ^ (lfsr_w[0] ? TAPS_W : 16'd0);
          state  <= REQ;
        end
        REQ: begin
          if (bus.cache_hit || bus.cache_miss) begin
            // A simultaneous hit+miss is a protocol violation, counted as a miss
            if (bus.cache_miss) miss_q <= sat_inc(miss_q);
            else                hit_q  <= sat_inc(hit_q);
            if (bus.cache_hit && bus.cache_miss) err_q <= 1'b1;
            if (bus.done_signal) begin
              rd_q  <= 1'b0;
              wr_q  <= 1'b0;
              state <= RELEASE;
            end else begin
              state <= WAIT_DONE;
            end
          end else if (bus.done_signal || tmo_fire) begin
            err_q <= 1'b1;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            state <= RELEASE;
          end
        end
        WAIT_DONE: begin
          if (bus.done_signal || tmo_fire) begin
            if (tmo_fire) err_q <= 1'b1;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          issued_q <= issued_q + CNT_W'(1);
          state    <= (issued_q + CNT_W'(1) == num_q) ? FINISH : SETUP;
        end
        FINISH: begin
          fin_q  <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy               = busy_q;
  assign finished           = fin_q;
  assign err                = err_q;
  assign hit_count          = hit_q;
  assign miss_count         = miss_q;
  assign bus.cpu_read       = rd_q;
  assign bus.cpu_write      = wr_q;
  assign bus.cpu_address    = addr_q;
  assign bus.cpu_write_data = data_q;
endmodule

// File: tb/tb_cache_traffic_gen.sv
// Directed bench for cache_traffic_gen: hand-computed addresses, data and counts.
// Builds with or without TRAFFIC_TIMEOUT_EN.
module tb_cache_traffic_gen;
`ifdef TRAFFIC_TIMEOUT_EN
  localparam int TCYC = 16;
`else
  localparam int TCYC = 1024;
`endif

  logic        clk, rst, start, busy, finished, err;
  logic [31:0] num, hit_count, miss_count;
  logic [4:0]  rl;
  logic [8:0]  wf;
`ifdef TRAFFIC_TIMEOUT_EN
  logic [31:0] timeout_count;
`endif
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_a [4];

  cache_traffic_gen_if #(.ADDR_W(32), .DATA_W(512)) bus ();

  cache_traffic_gen #(.TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst), .start(start), .num_accesses(num),
    .region_log2(rl), .write_frac(wf), .busy(busy), .finished(finished),
    .err(err), .hit_count(hit_count), .miss_count(miss_count),
`ifdef TRAFFIC_TIMEOUT_EN
    .timeout_count(timeout_count),
`endif
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] n, input logic [4:0] r, input logic [8:0] w);
    @(negedge clk);
    num = n; rl = r; wf = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for a request; prev_low tells whether the cycle before it was idle
  task automatic wait_req(input string tag, output logic prev_low);
    logic last, cur, ok;
    last = bus.cpu_read | bus.cpu_write;
    ok = 1'b0; prev_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cur = bus.cpu_read | bus.cpu_write;
      if (cur) begin ok = 1'b1; prev_low = !last; break; end
      last = cur;
    end
    check({tag, "_req_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic respond(input logic h, input logic m, input logic same);
    bus.cache_hit = h; bus.cache_miss = m; bus.done_signal = same;
    @(negedge clk);
    bus.cache_hit = 1'b0; bus.cache_miss = 1'b0;
    if (!same) begin
      bus.done_signal = 1'b1;
      @(negedge clk);
    end
    bus.done_signal = 1'b0;
  endtask

  task automatic wait_fin(input string tag, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (finished) begin seen = 1'b1; break; end
    end
    check({tag, "_finished"}, 64'(seen), 64'd1);
    check({tag, "_busy_at_fin"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic pl;
    exp_a[0] = 32'h1000_0068; exp_a[1] = 32'h1000_0034;
    exp_a[2] = 32'h1000_001A; exp_a[3] = 32'h1000_008D;
    rst = 1'b0; start = 1'b0; num = '0; rl = '0; wf = '0;
    bus.cache_hit = 1'b0; bus.cache_miss = 1'b0; bus.done_signal = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fin", 64'(finished), 64'd0);
    check("rst_rdwr", 64'({bus.cpu_read, bus.cpu_write}), 64'd0);
    check("rst_addr", 64'(bus.cpu_address), 64'd0);
    check("rst_counts", {hit_count, miss_count}, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b1;

    // 1: single read, hit then done one cycle later
    do_start(1, 0, 0);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_setup_idle", 64'({bus.cpu_read, bus.cpu_write}), 64'd0);
    @(negedge clk);
    check("t1_req_lat", 64'({bus.cpu_read, bus.cpu_write}), 64'b10);
    check("t1_addr", 64'(bus.cpu_address), 64'h1000_0000);
    respond(1, 0, 0);
    check("t1_release", 64'({bus.cpu_read, bus.cpu_write}), 64'd0);
    wait_fin("t1", 10);
    check("t1_hit", 64'(hit_count), 64'd1);
    check("t1_miss", 64'(miss_count), 64'd0);
    @(negedge clk);
    check("t1_pulse", 64'(finished), 64'd0);

    // 2: four writes, always miss, start pulsed mid-run is ignored
    do_start(4, 8, 256);
    for (int a = 0; a < 4; a++) begin
      wait_req("t2", pl);
      check("t2_prev_idle", 64'(pl), 64'd1);
      check("t2_rdwr", 64'({bus.cpu_read, bus.cpu_write}), 64'b01);
      check("t2_addr", 64'(bus.cpu_address), 64'(exp_a[a]));
      if (a == 0) begin
        check("t2_w0", 64'(bus.cpu_write_data[31:0]), 64'hACE1_2468);
        check("t2_w1", 64'(bus.cpu_write_data[63:32]), 64'h32D6_5DD1);
        check("t2_w2", 64'(bus.cpu_write_data[95:64]), 64'h908F_D71A);
      end
      if (a == 1) begin start = 1'b1; num = 0; end
      respond(0, 1, a >= 2);
      if (a == 2) start = 1'b0;
      check("t2_release", 64'({bus.cpu_read, bus.cpu_write}), 64'd0);
    end
    wait_fin("t2", 10);
    check("t2_miss", 64'(miss_count), 64'd4);
    check("t2_hit", 64'(hit_count), 64'd0);
    check("t2_err", 64'(err), 64'd0);

    // 3: zero accesses finishes two cycles after start
    do_start(0, 0, 0);
    check("t3_busy", 64'(busy), 64'd1);
    check("t3_fin_early", 64'(finished), 64'd0);
    @(negedge clk);
    check("t3_fin", 64'(finished), 64'd1);
    check("t3_busy_off", 64'(busy), 64'd0);
    check("t3_counts", {hit_count, miss_count}, 64'd0);
    check("t3_rdwr", 64'({bus.cpu_read, bus.cpu_write}), 64'd0);

    // 4: write_frac boundary (0xEF read, 0x77 write) and hit+miss collision
    do_start(2, 0, 239);
    wait_req("t4a", pl);
    check("t4_rd", 64'({bus.cpu_read, bus.cpu_write}), 64'b10);
    respond(1, 1, 0);
    wait_req("t4b", pl);
    check("t4_wr", 64'({bus.cpu_read, bus.cpu_write}), 64'b01);
    respond(1, 0, 1);
    wait_fin("t4", 10);
    check("t4_miss", 64'(miss_count), 64'd1);
    check("t4_hit", 64'(hit_count), 64'd1);
    check("t4_err", 64'(err), 64'd1);

    // 4b: done without hit or miss; err cleared by start first
    do_start(1, 0, 0);
    check("t4b_err_clr", 64'(err), 64'd0);
    wait_req("t4b", pl);
    respond(0, 0, 1);
    wait_fin("t4b", 10);
    check("t4b_err", 64'(err), 64'd1);
    check("t4b_counts", {hit_count, miss_count}, 64'd0);

    // 5: asynchronous reset while waiting for done
    do_start(3, 0, 0);
    wait_req("t5", pl);
    bus.cache_hit = 1'b1;
    @(negedge clk);
    bus.cache_hit = 1'b0;
    check("t5_hit_pre", 64'(hit_count), 64'd1);
    check("t5_rd_pre", 64'(bus.cpu_read), 64'd1);
    rst = 1'b0;
    #1;
    check("t5_rdwr", 64'({bus.cpu_read, bus.cpu_write}), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_counts", {hit_count, miss_count}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

`ifdef TRAFFIC_TIMEOUT_EN
    // 6: silent cache, watchdog releases both accesses
    do_start(2, 0, 0);
    wait_fin("t6", 200);
    check("t6_err", 64'(err), 64'd1);
    check("t6_tmo", 64'(timeout_count), 64'd2);
    check("t6_counts", {hit_count, miss_count}, 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
